// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer: drives counter enable/clear and selects live or frozen display digits.
// Optional LAP auto-return timer is built when AUTO_LAP_RETURN_EN is defined.
module stopwatch_ctrl #(
   parameter int unsigned LAP_TIMEOUT = 32'd300_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ss_in,
   input  logic        lr_in,
   input  logic [31:0] live_d,
   output logic        cnt_en,
   output logic        cnt_clr,
   output logic [31:0] disp_d,
   output logic        lap_active,
   output logic [1:0]  state_o
);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_LAP   = 2'b11;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic        r_ss_prev;
   logic        r_lr_prev;
   logic        r_cnt_en;
   logic        r_cnt_clr;
   logic        r_lap_active;
   logic [31:0] r_lap_reg;
   logic        w_ss_rise;
   logic        w_lr_rise;
   logic        w_clr_nxt;
   logic        w_lap_load;
   logic        w_timeout;
   logic        w_cnt_en_nxt;
   logic        w_lap_active_nxt;

   assign w_ss_rise = ss_in & ~r_ss_prev;
   assign w_lr_rise = lr_in & ~r_lr_prev;

`ifdef AUTO_LAP_RETURN_EN
   localparam int unsigned CW = $clog2(LAP_TIMEOUT + 32'd1);
   logic [CW-1:0] r_lap_cnt;

   // Cycles spent in LAP; restarts from zero on every LAP entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lap_cnt <= '0;
      end else if ((r_state == S_LAP) && (w_state_nxt == S_LAP)) begin
         r_lap_cnt <= r_lap_cnt + CW'(1);
      end else begin
         r_lap_cnt <= '0;
      end
   end

   assign w_timeout = (r_lap_cnt == CW'(LAP_TIMEOUT - 32'd1));
`else
   logic w_unused_cfg;
   assign w_unused_cfg = (LAP_TIMEOUT == 32'd0);
   assign w_timeout    = 1'b0;
`endif

   // State, edge-detect history and registered outputs; prev levels reset high so a held button is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_ss_prev    <= 1'b1;
         r_lr_prev    <= 1'b1;
         r_cnt_en     <= 1'b0;
         r_cnt_clr    <= 1'b0;
         r_lap_active <= 1'b0;
         r_lap_reg    <= 32'h0000_0000;
      end else begin
         r_state      <= w_state_nxt;
         r_ss_prev    <= ss_in;
         r_lr_prev    <= lr_in;
         r_cnt_en     <= w_cnt_en_nxt;
         r_cnt_clr    <= w_clr_nxt;
         r_lap_active <= w_lap_active_nxt;
         if (w_lap_load) begin
            r_lap_reg <= live_d;
         end else begin
            r_lap_reg <= r_lap_reg;
         end
      end
   end

   // Next-state decode; start/stop beats lap/reset when both rise together.
   always_comb begin
      w_state_nxt = r_state;
      w_clr_nxt   = 1'b0;
      w_lap_load  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_ss_rise) begin
               w_state_nxt = S_RUN;
            end else if (w_lr_rise) begin
               w_clr_nxt = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_ss_rise) begin
               w_state_nxt = S_PAUSE;
            end else if (w_lr_rise) begin
               w_state_nxt = S_LAP;
               w_lap_load  = 1'b1;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_LAP: begin
            if (w_ss_rise) begin
               w_state_nxt = S_PAUSE;
            end else if (w_lr_rise || w_timeout) begin
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_LAP;
            end
         end
         S_PAUSE: begin
            if (w_ss_rise) begin
               w_state_nxt = S_RUN;
            end else if (w_lr_rise) begin
               w_state_nxt = S_IDLE;
               w_clr_nxt   = 1'b1;
            end else begin
               w_state_nxt = S_PAUSE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Output decode: register inputs from next state, display select from current state.
   always_comb begin
      w_cnt_en_nxt     = (w_state_nxt == S_RUN) || (w_state_nxt == S_LAP);
      w_lap_active_nxt = (w_state_nxt == S_LAP);
      if (r_state == S_LAP) begin
         disp_d = r_lap_reg;
      end else begin
         disp_d = live_d;
      end
   end

   assign cnt_en     = r_cnt_en;
   assign cnt_clr    = r_cnt_clr;
   assign lap_active = r_lap_active;
   assign state_o    = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random button/digit traffic
// compared against an event-level stopwatch model (running / frozen / touched-since-clear).
module tb_stopwatch_ctrl;

   localparam int unsigned TMO = 20;

   logic        clk;
   logic        rst;
   logic        ss_in;
   logic        lr_in;
   logic [31:0] live_d;
   logic        cnt_en;
   logic        cnt_clr;
   logic [31:0] disp_d;
   logic        lap_active;
   logic [1:0]  state_o;

   int n_cmp;
   int n_fail;

   // Reference model: stopwatch semantics rather than an FSM encoding.
   bit          m_running;
   bit          m_frozen;
   bit          m_touched;
   bit          m_clr;
   bit          m_pss;
   bit          m_plr;
   logic [31:0] m_lap;
`ifdef AUTO_LAP_RETURN_EN
   int          m_lc;
`endif

   stopwatch_ctrl #(.LAP_TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .ss_in      (ss_in),
      .lr_in      (lr_in),
      .live_d     (live_d),
      .cnt_en     (cnt_en),
      .cnt_clr    (cnt_clr),
      .disp_d     (disp_d),
      .lap_active (lap_active),
      .state_o    (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] m_code();
      if (m_running) return m_frozen ? 2'b11 : 2'b01;
      else           return m_touched ? 2'b10 : 2'b00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".state"},  {30'd0, state_o},    {30'd0, m_code()});
      chk({tag, ".cnt_en"}, {31'd0, cnt_en},     {31'd0, m_running});
      chk({tag, ".clr"},    {31'd0, cnt_clr},    {31'd0, m_clr});
      chk({tag, ".lap"},    {31'd0, lap_active}, {31'd0, m_frozen});
      chk({tag, ".disp"},   disp_d,              m_frozen ? m_lap : live_d);
   endtask

   task automatic model_reset();
      m_running = 1'b0; m_frozen = 1'b0; m_touched = 1'b0; m_clr = 1'b0;
      m_pss = 1'b1; m_plr = 1'b1; m_lap = 32'h0;
`ifdef AUTO_LAP_RETURN_EN
      m_lc = 0;
`endif
   endtask

   task automatic model_step();
      bit ssr;
      bit lrr;
      ssr   = ss_in && !m_pss;
      lrr   = lr_in && !m_plr;
      m_pss = ss_in;
      m_plr = lr_in;
      m_clr = 1'b0;
      if (ssr) begin
         if (m_running) begin m_running = 1'b0; m_frozen = 1'b0; end
         else begin m_running = 1'b1; m_touched = 1'b1; end
      end else if (lrr) begin
         if (m_running && m_frozen) m_frozen = 1'b0;
         else if (m_running) begin
            m_frozen = 1'b1;
            m_lap    = live_d;
`ifdef AUTO_LAP_RETURN_EN
            m_lc     = 0;
`endif
         end else begin
            m_touched = 1'b0;
            m_clr     = 1'b1;
         end
      end else if (m_running && m_frozen) begin
`ifdef AUTO_LAP_RETURN_EN
         if (m_lc == int'(TMO) - 1) m_frozen = 1'b0;
         else m_lc++;
`endif
      end
   endtask

   task automatic cyc(input logic ss, input logic lr, input logic [31:0] live, input string tag);
      @(negedge clk);
      ss_in  = ss;
      lr_in  = lr;
      live_d = live;
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst    = 1'b1;
      ss_in  = 1'b1;
      lr_in  = 1'b0;
      live_d = 32'h0;
      model_reset();
      #1;
      check_all("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 1: start/stop held through reset gives no edge; a fresh press starts the watch
      cyc(1'b1, 1'b0, 32'h0, "t1.held");
      cyc(1'b1, 1'b0, 32'h0, "t1.held");
      chk("t1.idle_state", {30'd0, state_o}, 32'd0);
      chk("t1.idle_en", {31'd0, cnt_en}, 32'd0);
      cyc(1'b0, 1'b0, 32'h0, "t1.drop");
      cyc(1'b1, 1'b0, 32'h0, "t1.rise");
      chk("t1.run_state", {30'd0, state_o}, 32'd1);
      chk("t1.run_en", {31'd0, cnt_en}, 32'd1);

      // 2: lap freeze and release
      cyc(1'b0, 1'b0, 32'h0012_3456, "t2.pre");
      cyc(1'b0, 1'b1, 32'h0012_3456, "t2.lap");
      chk("t2.lap_state", {30'd0, state_o}, 32'd3);
      chk("t2.lap_active", {31'd0, lap_active}, 32'd1);
      chk("t2.lap_disp", disp_d, 32'h0012_3456);
      cyc(1'b0, 1'b0, 32'h0012_3999, "t2.frozen");
      chk("t2.frozen_disp", disp_d, 32'h0012_3456);
      cyc(1'b0, 1'b1, 32'h0012_3999, "t2.unlap");
      chk("t2.unlap_state", {30'd0, state_o}, 32'd1);
      chk("t2.unlap_disp", disp_d, 32'h0012_3999);

      // 3: pause then clear
      cyc(1'b0, 1'b0, 32'h0000_0042, "t3.pre");
      cyc(1'b1, 1'b0, 32'h0000_0042, "t3.pause");
      chk("t3.pause_state", {30'd0, state_o}, 32'd2);
      chk("t3.pause_en", {31'd0, cnt_en}, 32'd0);
      cyc(1'b0, 1'b0, 32'h0000_0042, "t3.gap");
      cyc(1'b0, 1'b1, 32'h0000_0042, "t3.clear");
      chk("t3.clear_state", {30'd0, state_o}, 32'd0);
      chk("t3.clr_pulse", {31'd0, cnt_clr}, 32'd1);
      cyc(1'b0, 1'b1, 32'h0, "t3.after");
      chk("t3.clr_end", {31'd0, cnt_clr}, 32'd0);

      // 4: simultaneous rises from RUN pause only; held lap button does nothing
      cyc(1'b1, 1'b0, 32'h0000_0100, "t4.run");
      cyc(1'b0, 1'b0, 32'h0000_0100, "t4.gap");
      cyc(1'b1, 1'b1, 32'h0000_0200, "t4.both");
      chk("t4.both_state", {30'd0, state_o}, 32'd2);
      chk("t4.both_clr", {31'd0, cnt_clr}, 32'd0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'h0000_0300, "t4.hold");
      chk("t4.hold_state", {30'd0, state_o}, 32'd2);

`ifdef AUTO_LAP_RETURN_EN
      // 5: automatic return from LAP, and a button rise preempting it
      cyc(1'b0, 1'b0, 32'h0, "t5.gap");
      cyc(1'b1, 1'b0, 32'h0, "t5.run");
      cyc(1'b0, 1'b0, 32'h0, "t5.gap");
      cyc(1'b0, 1'b1, 32'h0000_5555, "t5.lap");
      for (int i = 1; i < int'(TMO); i++) begin
         cyc(1'b0, 1'b0, 32'h0000_6666, "t5.wait");
         chk("t5.still_lap", {30'd0, state_o}, 32'd3);
      end
      cyc(1'b0, 1'b0, 32'h0000_6666, "t5.timeout");
      chk("t5.auto_run", {30'd0, state_o}, 32'd1);
      cyc(1'b0, 1'b1, 32'h0000_7777, "t5.lap2");
      cyc(1'b0, 1'b0, 32'h0000_7777, "t5.gap2");
      for (int i = 2; i < 10; i++) cyc(1'b0, 1'b0, 32'h0000_7777, "t5.wait2");
      cyc(1'b0, 1'b1, 32'h0000_7777, "t5.press10");
      chk("t5.press_run", {30'd0, state_o}, 32'd1);
      for (int i = 0; i < 25; i++) cyc(1'b0, 1'b1, 32'h0000_8888, "t5.after");
      chk("t5.no_second", {30'd0, state_o}, 32'd1);
`endif

      // random traffic against the model
      for (int i = 0; i < 800; i++) begin
         cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom, "rnd");
      end

      // 6: asynchronous reset while in LAP
      cyc(1'b0, 1'b0, 32'h1111_2222, "t6.gap");
      if (!m_running) cyc(1'b1, 1'b0, 32'h1111_2222, "t6.start");
      cyc(1'b0, 1'b0, 32'h1111_2222, "t6.gap");
      if (m_frozen) cyc(1'b0, 1'b1, 32'h1111_2222, "t6.unlap");
      cyc(1'b0, 1'b0, 32'h1111_2222, "t6.gap");
      cyc(1'b0, 1'b1, 32'h1111_3333, "t6.lap");
      chk("t6.in_lap", {30'd0, state_o}, 32'd3);
      @(negedge clk);
      live_d = 32'h9876_5432;
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all("t6.rst");
      chk("t6.rst_disp", disp_d, 32'h9876_5432);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("t6.no_clr", {31'd0, cnt_clr}, 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 32'h0000_0777, "t6.post");
      chk("t6.post_state", {30'd0, state_o}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
